// File: rtl/regbank_scoreboard_pkg.sv
// Shared defaults for the register bank with pending-write scoreboard.
// Holds the default geometry and a helper that gives the largest value a
// pending-write counter of a given width can hold.
package regbank_scoreboard_pkg;

  localparam int DefAddrBits = 5;
  localparam int DefWordW    = 32;
  localparam int DefCntBits  = 2;

  // Largest in-flight write count a CNT_BITS-wide counter can hold.
  function automatic int cntMax(input int cntBits);
    return (1 << cntBits) - 1;
  endfunction

endpackage

// File: rtl/regbank_scoreboard_if.sv
// Bus between decode/writeback and the register bank.
// Carries the writeback port (regWrite/writeReg/writeData), the two read
// ports (readReg1/2 -> readData1/2), the issue request (issue_valid, use1,
// use2, issue_dest, has_dest) and the scoreboard status (stall, sb_error).
//   master : pipeline side, drives requests and observes data/status
//   slave  : register bank side
interface regbank_scoreboard_if
  import regbank_scoreboard_pkg::*;
#(
  parameter int ADDR_BITS = DefAddrBits,
  parameter int WORD_W    = DefWordW
);

  logic                 regWrite;
  logic [ADDR_BITS-1:0] writeReg;
  logic [WORD_W-1:0]    writeData;
  logic [ADDR_BITS-1:0] readReg1;
  logic [ADDR_BITS-1:0] readReg2;
  logic [WORD_W-1:0]    readData1;
  logic [WORD_W-1:0]    readData2;
  logic                 issue_valid;
  logic                 use1;
  logic                 use2;
  logic [ADDR_BITS-1:0] issue_dest;
  logic                 has_dest;
  logic                 stall;
  logic                 sb_error;

  modport master (
    output regWrite, writeReg, writeData, readReg1, readReg2,
    output issue_valid, use1, use2, issue_dest, has_dest,
    input  readData1, readData2, stall, sb_error
  );

  modport slave (
    input  regWrite, writeReg, writeData, readReg1, readReg2,
    input  issue_valid, use1, use2, issue_dest, has_dest,
    output readData1, readData2, stall, sb_error
  );

endinterface

// File: rtl/regbank_scoreboard_sb_cnt.sv
// Pending-write counter for one register.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   inc          : an instruction writing this register was issued
//   dec          : a writeback to this register retired
//   cnt          : current number of in-flight writes
//   nonzero      : cnt != 0
//   atMax        : cnt is at its largest value
//   underflow    : dec requested while cnt == 0 (retire without an issue)
// inc and dec together leave the count unchanged. The count never wraps:
// it holds at 0 on a stray retire and at max if incremented there.
module regbank_scoreboard_sb_cnt
  import regbank_scoreboard_pkg::*;
#(
  parameter int CNT_BITS = DefCntBits
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inc,
  input  logic                dec,
  output logic [CNT_BITS-1:0] cnt,
  output logic                nonzero,
  output logic                atMax,
  output logic                underflow
);

  localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(cntMax(CNT_BITS));

  assign nonzero   = (cnt != '0);
  assign atMax     = (cnt == CntMax);
  assign underflow = dec && !nonzero;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !dec && !atMax) begin
      cnt <= cnt + CNT_BITS'(1);
    end else if (dec && !inc && nonzero) begin
      cnt <= cnt - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/regbank_scoreboard.sv
// Register bank with write-through bypass and pending-write scoreboard.
// One write port, two combinational read ports, optional hardwired-zero
// register 0, and one pending-write counter per register. Decode presents
// an instruction on the issue signals; stall refuses it on a RAW hazard
// (a source still has an outstanding write) or when the destination's
// counter is saturated. Writeback retires one pending write per regWrite.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : writeback, read ports, issue request, stall, sb_error
// Parameters: ADDR_BITS (depth = 1<<ADDR_BITS), WORD_W, ZERO_REG, CNT_BITS.
module regbank_scoreboard
  import regbank_scoreboard_pkg::*;
#(
  parameter int ADDR_BITS = DefAddrBits,
  parameter int WORD_W    = DefWordW,
  parameter bit ZERO_REG  = 1'b1,
  parameter int CNT_BITS  = DefCntBits
) (
  input logic                  clock,
  input logic                  reset,
  regbank_scoreboard_if.slave  bus
);

  localparam int Depth = 1 << ADDR_BITS;

  logic [WORD_W-1:0]   bank [Depth];
  logic [CNT_BITS-1:0] cntArr [Depth];
  logic [Depth-1:0]    incVec;
  logic [Depth-1:0]    decVec;
  logic [Depth-1:0]    nonzeroVec;
  logic [Depth-1:0]    atMaxVec;
  logic [Depth-1:0]    underflowVec;

  logic retire;
  logic accept;
  logic srcHaz1;
  logic srcHaz2;
  logic wawSat;
  logic sbError;

  // Register 0 behaves as a constant when ZERO_REG is set.
  function automatic logic isHardZero(input logic [ADDR_BITS-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  assign retire = bus.regWrite && !isHardZero(bus.writeReg);

  // A source whose only outstanding write retires this very cycle is
  // already satisfied through the bypass, so it does not stall.
  assign srcHaz1 = bus.use1 && !isHardZero(bus.readReg1) && nonzeroVec[bus.readReg1]
                && !(retire && (bus.writeReg == bus.readReg1)
                     && (cntArr[bus.readReg1] == CNT_BITS'(1)));
  assign srcHaz2 = bus.use2 && !isHardZero(bus.readReg2) && nonzeroVec[bus.readReg2]
                && !(retire && (bus.writeReg == bus.readReg2)
                     && (cntArr[bus.readReg2] == CNT_BITS'(1)));

  // A retire to the destination in the same cycle frees a slot, so the
  // counter stays at max instead of overflowing.
  assign wawSat = bus.has_dest && !isHardZero(bus.issue_dest) && atMaxVec[bus.issue_dest]
               && !(retire && (bus.writeReg == bus.issue_dest));

  assign bus.stall = bus.issue_valid && (srcHaz1 || srcHaz2 || wawSat);

  assign accept = bus.issue_valid && !bus.stall && bus.has_dest
               && !isHardZero(bus.issue_dest);

  for (genvar r = 0; r < Depth; r++) begin : gCnt
    assign incVec[r] = accept && (bus.issue_dest == ADDR_BITS'(r));
    assign decVec[r] = retire && (bus.writeReg == ADDR_BITS'(r));

    regbank_scoreboard_sb_cnt #(
      .CNT_BITS (CNT_BITS)
    ) uCnt (
      .clock     (clock),
      .reset     (reset),
      .inc       (incVec[r]),
      .dec       (decVec[r]),
      .cnt       (cntArr[r]),
      .nonzero   (nonzeroVec[r]),
      .atMax     (atMaxVec[r]),
      .underflow (underflowVec[r])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        bank[i] <= '0;
      end
    end else if (retire) begin
      bank[bus.writeReg] <= bus.writeData;
    end
  end

  // Sticky: a retire with nothing pending means the pipeline lost track.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sbError <= 1'b0;
    end else if (|underflowVec) begin
      sbError <= 1'b1;
    end
  end

  assign bus.sb_error = sbError;

  assign bus.readData1 = isHardZero(bus.readReg1) ? '0 :
                         (bus.regWrite && (bus.writeReg == bus.readReg1)) ? bus.writeData :
                         bank[bus.readReg1];
  assign bus.readData2 = isHardZero(bus.readReg2) ? '0 :
                         (bus.regWrite && (bus.writeReg == bus.readReg2)) ? bus.writeData :
                         bank[bus.readReg2];

endmodule
